// File: rtl/reg_mem_sram_adapter.sv
// ---------------------------------------------------------------------------
// reg_mem_sram_adapter
//
// Memory-side endpoint of the register-to-memory bridge. It accepts one
// mem_* request at a time and turns it into a single access on a
// single-port synchronous SRAM that has a fixed read latency. It returns a
// one-cycle acknowledge, together with the captured read data and an error
// flag. Malformed requests (both enables set or neither set) and requests to
// an address outside the implemented depth are acknowledged with mem_err=1.
// Those requests never touch the SRAM.
//
// Parameters
//   MEM_DATA_WIDTH  : data width of the request path and of the SRAM
//   MEM_ADDR_WIDTH  : entry address width
//   MEM_DEPTH       : implemented entries, 1..2**MEM_ADDR_WIDTH
//   SRAM_RD_LATENCY : cycles from the sram_ce read cycle to valid sram_rdata
//                     (1..4)
//
// Ports
//   mem_clk      in   single clock
//   mem_rst      in   asynchronous active-high reset
//   mem_req_vld  in   request level, held until mem_ack_vld
//   mem_ack_vld  out  one-cycle completion pulse
//   mem_addr     in   entry address
//   mem_wr_en    in   write request
//   mem_rd_en    in   read request
//   mem_wr_data  in   write data
//   mem_rd_data  out  read data, valid with mem_ack_vld and held afterwards
//   mem_err      out  error status, valid with mem_ack_vld
//   sram_ce      out  SRAM chip enable, one cycle per access
//   sram_we      out  SRAM write enable, qualified by sram_ce
//   sram_addr    out  SRAM address
//   sram_wdata   out  SRAM write data
//   sram_rdata   in   SRAM read data
// ---------------------------------------------------------------------------
module reg_mem_sram_adapter #(
  parameter int MEM_DATA_WIDTH  = 64,
  parameter int MEM_ADDR_WIDTH  = 1,
  parameter int MEM_DEPTH       = 2,
  parameter int SRAM_RD_LATENCY = 1
) (
  input  logic                      mem_clk,
  input  logic                      mem_rst,
  input  logic                      mem_req_vld,
  output logic                      mem_ack_vld,
  input  logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  input  logic                      mem_wr_en,
  input  logic                      mem_rd_en,
  input  logic [MEM_DATA_WIDTH-1:0] mem_wr_data,
  output logic [MEM_DATA_WIDTH-1:0] mem_rd_data,
  output logic                      mem_err,
  output logic                      sram_ce,
  output logic                      sram_we,
  output logic [MEM_ADDR_WIDTH-1:0] sram_addr,
  output logic [MEM_DATA_WIDTH-1:0] sram_wdata,
  input  logic [MEM_DATA_WIDTH-1:0] sram_rdata
);

  // The counter is loaded with SRAM_RD_LATENCY and counts down to zero,
  // so it needs to be just wide enough to hold that value.
  localparam int CNT_W = $clog2(SRAM_RD_LATENCY + 1);

  // The depth limit carries one extra bit, so MEM_DEPTH == 2**MEM_ADDR_WIDTH
  // can be represented and every address is then in range.
  localparam logic [MEM_ADDR_WIDTH:0] DEPTH_LIM  = (MEM_ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [CNT_W-1:0]        LAT_LOAD   = CNT_W'(SRAM_RD_LATENCY);
  localparam logic [CNT_W-1:0]        CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR      = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_ACK     = 2'd3
  } state_t;

  state_t                      state_reg,       state_next;
  logic [CNT_W-1:0]            lat_cnt_reg,     lat_cnt_next;
  logic                        sram_ce_reg,     sram_ce_next;
  logic                        sram_we_reg,     sram_we_next;
  logic [MEM_ADDR_WIDTH-1:0]   sram_addr_reg,   sram_addr_next;
  logic [MEM_DATA_WIDTH-1:0]   sram_wdata_reg,  sram_wdata_next;
  logic                        mem_ack_vld_reg, mem_ack_vld_next;
  logic                        mem_err_reg,     mem_err_next;
  logic [MEM_DATA_WIDTH-1:0]   mem_rd_data_reg, mem_rd_data_next;

  logic                        one_hot_en;
  logic                        addr_in_range;
  logic                        req_ok;

  // A request is well formed only if exactly one of the enables is set and
  // the address falls inside the implemented entries.
  assign one_hot_en    = mem_wr_en ^ mem_rd_en;
  assign addr_in_range = ({1'b0, mem_addr} < DEPTH_LIM);
  assign req_ok        = one_hot_en & addr_in_range;

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge mem_clk or posedge mem_rst) begin
    if (mem_rst) begin
      state_reg       <= ST_IDLE;
      lat_cnt_reg     <= '0;
      sram_ce_reg     <= 1'b0;
      sram_we_reg     <= 1'b0;
      sram_addr_reg   <= '0;
      sram_wdata_reg  <= '0;
      mem_ack_vld_reg <= 1'b0;
      mem_err_reg     <= 1'b0;
      mem_rd_data_reg <= '0;
    end else begin
      state_reg       <= state_next;
      lat_cnt_reg     <= lat_cnt_next;
      sram_ce_reg     <= sram_ce_next;
      sram_we_reg     <= sram_we_next;
      sram_addr_reg   <= sram_addr_next;
      sram_wdata_reg  <= sram_wdata_next;
      mem_ack_vld_reg <= mem_ack_vld_next;
      mem_err_reg     <= mem_err_next;
      mem_rd_data_reg <= mem_rd_data_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and next-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    // The defaults make the pulse outputs (ce, we, ack, err) idle low.
    // The latched SRAM fields, the counter and the read data hold.
    state_next       = state_reg;
    lat_cnt_next     = lat_cnt_reg;
    sram_ce_next     = 1'b0;
    sram_we_next     = 1'b0;
    sram_addr_next   = sram_addr_reg;
    sram_wdata_next  = sram_wdata_reg;
    mem_ack_vld_next = 1'b0;
    mem_err_next     = 1'b0;
    mem_rd_data_next = mem_rd_data_reg;

    case (state_reg)
      ST_IDLE: begin
        if (mem_req_vld) begin
          if (req_ok) begin
            // The request fields are latched here. Later changes on the
            // mem_* inputs have no effect until the FSM is back in IDLE.
            sram_ce_next    = 1'b1;
            sram_we_next    = mem_wr_en;
            sram_addr_next  = mem_addr;
            sram_wdata_next = mem_wr_data;
            if (mem_wr_en) begin
              state_next = ST_WR;
            end else begin
              lat_cnt_next = LAT_LOAD;
              state_next   = ST_RD_WAIT;
            end
          end else begin
            // This request is rejected without any SRAM access.
            // The read data is cleared, so stale data cannot look valid.
            mem_ack_vld_next = 1'b1;
            mem_err_next     = 1'b1;
            mem_rd_data_next = '0;
            state_next       = ST_ACK;
          end
        end
      end

      ST_WR: begin
        // sram_ce is high during this single cycle and the write
        // completes at its end.
        mem_ack_vld_next = 1'b1;
        state_next       = ST_ACK;
      end

      ST_RD_WAIT: begin
        // The counter equals SRAM_RD_LATENCY in the sram_ce cycle, so it
        // reaches zero in the exact cycle sram_rdata becomes valid.
        if (lat_cnt_reg == '0) begin
          mem_rd_data_next = sram_rdata;
          mem_ack_vld_next = 1'b1;
          state_next       = ST_ACK;
        end else begin
          lat_cnt_next = lat_cnt_reg - CNT_ONE;
        end
      end

      ST_ACK: begin
        // mem_req_vld is deliberately ignored in this cycle, because
        // upstream has not yet seen the acknowledge.
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign mem_ack_vld = mem_ack_vld_reg;
  assign mem_err     = mem_err_reg;
  assign mem_rd_data = mem_rd_data_reg;
  assign sram_ce     = sram_ce_reg;
  assign sram_we     = sram_we_reg;
  assign sram_addr   = sram_addr_reg;
  assign sram_wdata  = sram_wdata_reg;

endmodule

// File: tb/tb_reg_mem_sram_adapter.sv
// ---------------------------------------------------------------------------
// tb_reg_mem_sram_adapter
//
// Self-checking bench for reg_mem_sram_adapter. It instantiates three copies
// with SRAM_RD_LATENCY = 1, 2 and 4. Each copy has MEM_ADDR_WIDTH=2 and
// MEM_DEPTH=3, so address 3 is out of range. Each copy also drives its own
// behavioural SRAM model. Outside a read, the model's read pipeline carries a
// poison word, so a capture in the wrong cycle returns visibly bad data.
// ---------------------------------------------------------------------------
module tb_reg_mem_sram_adapter;

  localparam int DW = 64;
  localparam int AW = 2;
  localparam int DEPTH = 3;
  localparam int NI = 3;
  localparam logic [DW-1:0] POISON = 64'hBAD0_BAD0_BAD0_BAD0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          req_vld [NI];
  logic          wr_en   [NI];
  logic          rd_en   [NI];
  logic [AW-1:0] addr    [NI];
  logic [DW-1:0] wdata   [NI];
  logic          ack     [NI];
  logic          err     [NI];
  logic [DW-1:0] rdata   [NI];
  logic          ce      [NI];
  logic          we      [NI];
  logic [AW-1:0] s_addr  [NI];
  logic [DW-1:0] s_wdata [NI];
  logic [DW-1:0] s_rdata [NI];

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int LAT = (gi == 0) ? 1 : (gi == 1) ? 2 : 4;
      logic [DW-1:0] mem  [1 << AW];
      logic [DW-1:0] pipe [LAT];

      reg_mem_sram_adapter #(
        .MEM_DATA_WIDTH (DW),
        .MEM_ADDR_WIDTH (AW),
        .MEM_DEPTH      (DEPTH),
        .SRAM_RD_LATENCY(LAT)
      ) u_dut (
        .mem_clk    (clk),
        .mem_rst    (rst),
        .mem_req_vld(req_vld[gi]),
        .mem_ack_vld(ack[gi]),
        .mem_addr   (addr[gi]),
        .mem_wr_en  (wr_en[gi]),
        .mem_rd_en  (rd_en[gi]),
        .mem_wr_data(wdata[gi]),
        .mem_rd_data(rdata[gi]),
        .mem_err    (err[gi]),
        .sram_ce    (ce[gi]),
        .sram_we    (we[gi]),
        .sram_addr  (s_addr[gi]),
        .sram_wdata (s_wdata[gi]),
        .sram_rdata (s_rdata[gi])
      );

      // The SRAM model has fixed read latency LAT and is never reset, so
      // its contents survive an adapter reset.
      always @(posedge clk) begin
        if (ce[gi] && we[gi]) mem[s_addr[gi]] <= s_wdata[gi];
        pipe[0] <= (ce[gi] && !we[gi]) ? mem[s_addr[gi]] : POISON;
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
      end
      assign s_rdata[gi] = pipe[LAT-1];
    end
  endgenerate

  int checks = 0;
  int errors = 0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // This task runs one transaction. The request is driven on a negedge,
  // and the posedge that follows samples it (cycle 0). Outputs are sampled
  // on each following negedge as cycles 1..20.
  task automatic run_txn(input int i, input logic w, input logic r,
                         input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output int ack_cyc, output logic e, output int ce_cnt,
                         output logic we_bad, output logic [AW-1:0] ce_addr,
                         output logic [DW-1:0] rd);
    @(negedge clk);
    wr_en[i] = w; rd_en[i] = r; addr[i] = a; wdata[i] = d; req_vld[i] = 1'b1;
    ack_cyc = -1; e = 1'b0; ce_cnt = 0; we_bad = 1'b0; ce_addr = '0; rd = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (ce[i]) begin
        ce_cnt++;
        ce_addr = s_addr[i];
        if (we[i] !== w) we_bad = 1'b1;
      end else if (we[i]) begin
        we_bad = 1'b1;
      end
      if (ack[i]) begin
        ack_cyc = c;
        e = err[i];
        rd = rdata[i];
        req_vld[i] = 1'b0;
        break;
      end
    end
    req_vld[i] = 1'b0;
  endtask

  typedef struct {
    int            inst;
    logic          wr;
    logic          rd;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            exp_ack;
    logic          exp_err;
    int            exp_ce;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int            ack_cyc, ce_cnt, nacks;
    logic          e, we_bad;
    logic [AW-1:0] ce_addr;
    logic [DW-1:0] rd, held_exp;
    logic [15:0]   ce_mask, ack_mask;
    logic          any_out;

    for (int i = 0; i < NI; i++) begin
      req_vld[i] = 1'b0; wr_en[i] = 1'b0; rd_en[i] = 1'b0;
      addr[i] = '0; wdata[i] = '0;
    end

    //            inst wr    rd    a     d                        ack err  ce rdata
    vecs[0]  = '{0, 1'b1, 1'b0, 2'd1, 64'hDEAD_BEEF_0123_4567, 2, 1'b0, 1, 64'h0};
    vecs[1]  = '{0, 1'b0, 1'b1, 2'd1, 64'h0,                   3, 1'b0, 1, 64'hDEAD_BEEF_0123_4567};
    vecs[2]  = '{0, 1'b1, 1'b0, 2'd2, 64'h1111_2222_3333_4444, 2, 1'b0, 1, 64'hDEAD_BEEF_0123_4567};
    vecs[3]  = '{0, 1'b0, 1'b1, 2'd2, 64'h0,                   3, 1'b0, 1, 64'h1111_2222_3333_4444};
    vecs[4]  = '{0, 1'b1, 1'b1, 2'd0, 64'h0,                   1, 1'b1, 0, 64'h0};
    vecs[5]  = '{0, 1'b0, 1'b0, 2'd0, 64'h0,                   1, 1'b1, 0, 64'h0};
    vecs[6]  = '{0, 1'b0, 1'b1, 2'd3, 64'h0,                   1, 1'b1, 0, 64'h0};
    vecs[7]  = '{0, 1'b1, 1'b0, 2'd3, 64'hFFFF_0000_FFFF_0000, 1, 1'b1, 0, 64'h0};
    vecs[8]  = '{0, 1'b0, 1'b1, 2'd1, 64'h0,                   3, 1'b0, 1, 64'hDEAD_BEEF_0123_4567};
    vecs[9]  = '{1, 1'b1, 1'b0, 2'd0, 64'hCAFE_F00D_1234_5678, 2, 1'b0, 1, 64'h0};
    vecs[10] = '{1, 1'b0, 1'b1, 2'd0, 64'h0,                   4, 1'b0, 1, 64'hCAFE_F00D_1234_5678};
    vecs[11] = '{1, 1'b0, 1'b1, 2'd3, 64'h0,                   1, 1'b1, 0, 64'h0};
    vecs[12] = '{2, 1'b1, 1'b0, 2'd2, 64'h0123_4567_89AB_CDEF, 2, 1'b0, 1, 64'h0};
    vecs[13] = '{2, 1'b0, 1'b1, 2'd2, 64'h0,                   6, 1'b0, 1, 64'h0123_4567_89AB_CDEF};
    vecs[14] = '{2, 1'b1, 1'b1, 2'd1, 64'h0,                   1, 1'b1, 0, 64'h0};
    vecs[15] = '{2, 1'b0, 1'b1, 2'd2, 64'h0,                   6, 1'b0, 1, 64'h0123_4567_89AB_CDEF};

    // ---- Reset, then 20 idle cycles: every output must stay 0 ----
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        any_out = ce[i] | we[i] | ack[i] | err[i] | (|rdata[i]) | (|s_addr[i]) | (|s_wdata[i]);
        check64($sformatf("idle_outputs_inst%0d", i), {63'h0, any_out}, 64'h0);
      end
    end
    $display("txn idle window: 20 cycles, all instances quiet");

    // ---- Table-driven transactions ----
    for (int v = 0; v < NV; v++) begin
      run_txn(vecs[v].inst, vecs[v].wr, vecs[v].rd, vecs[v].a, vecs[v].d,
              ack_cyc, e, ce_cnt, we_bad, ce_addr, rd);
      $display("txn %0d inst %0d wr=%0b rd=%0b addr=%0d ack_cycle=%0d err=%0b ce_cycles=%0d rdata=%h",
               v, vecs[v].inst, vecs[v].wr, vecs[v].rd, vecs[v].a, ack_cyc, e, ce_cnt, rd);
      check64($sformatf("v%0d_ack_cycle", v), 64'(ack_cyc), 64'(vecs[v].exp_ack));
      check64($sformatf("v%0d_err", v), {63'h0, e}, {63'h0, vecs[v].exp_err});
      check64($sformatf("v%0d_ce_cycles", v), 64'(ce_cnt), 64'(vecs[v].exp_ce));
      check64($sformatf("v%0d_we_qual", v), {63'h0, we_bad}, 64'h0);
      check64($sformatf("v%0d_rdata", v), rd, vecs[v].exp_rdata);
      if (vecs[v].exp_ce != 0)
        check64($sformatf("v%0d_sram_addr", v), {62'h0, ce_addr}, {62'h0, vecs[v].a});
    end

    // ---- Held request, instance 0 (L=1): alternate write/read to addr 0 ----
    held_exp = 64'hA5A5_A5A5_5A5A_5A5A;
    @(negedge clk);
    wr_en[0] = 1'b1; rd_en[0] = 1'b0; addr[0] = 2'd0; wdata[0] = held_exp; req_vld[0] = 1'b1;
    ce_mask = '0; ack_mask = '0; nacks = 0;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (ce[0]) ce_mask[c] = 1'b1;
      if (ack[0]) begin
        ack_mask[c] = 1'b1;
        nacks++;
        if (rd_en[0]) begin
          check64($sformatf("held_read%0d_rdata", nacks), rdata[0], held_exp);
          wr_en[0] = 1'b1; rd_en[0] = 1'b0;
          held_exp = 64'h0F0F_1234_F0F0_4321;
          wdata[0] = held_exp;
        end else begin
          wr_en[0] = 1'b0; rd_en[0] = 1'b1;
        end
      end
    end
    req_vld[0] = 1'b0;
    $display("txn held stream: ce_mask=%h ack_mask=%h acks=%0d", ce_mask, ack_mask, nacks);
    check64("held_ce_cycles", {48'h0, ce_mask}, 64'h0912);
    check64("held_ack_cycles", {48'h0, ack_mask}, 64'h2244);

    // ---- Reset in the middle of a read, instance 2 (L=4) ----
    @(negedge clk);
    @(negedge clk);
    wr_en[2] = 1'b0; rd_en[2] = 1'b1; addr[2] = 2'd2; req_vld[2] = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) check64("midrst_ce_cycle1", {63'h0, ce[2]}, 64'h1);
    end
    rst = 1'b1;
    req_vld[2] = 1'b0;
    #1;
    check64("midrst_ce", {63'h0, ce[2]}, 64'h0);
    check64("midrst_ack", {63'h0, ack[2]}, 64'h0);
    check64("midrst_rdata", rdata[2], 64'h0);
    check64("midrst_addr", {62'h0, s_addr[2]}, 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nacks = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ack[2]) nacks++;
    end
    check64("midrst_no_ack", 64'(nacks), 64'h0);
    $display("txn reset mid-read: acks after reset=%0d", nacks);

    run_txn(2, 1'b0, 1'b1, 2'd2, 64'h0, ack_cyc, e, ce_cnt, we_bad, ce_addr, rd);
    $display("txn post-reset read inst 2 ack_cycle=%0d err=%0b rdata=%h", ack_cyc, e, rd);
    check64("postrst_ack_cycle", 64'(ack_cyc), 64'd6);
    check64("postrst_err", {63'h0, e}, 64'h0);
    check64("postrst_rdata", rd, 64'h0123_4567_89AB_CDEF);
    check64("postrst_ce_cycles", 64'(ce_cnt), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_mem_sram_adapter.md
# reg_mem_sram_adapter

Memory-side endpoint of the register native-interface-to-memory bridge. Consumes the `mem_*` request/acknowledge handshake produced by the bridge and drives a single-port synchronous SRAM macro with a fixed read latency. It returns a one-cycle acknowledge and captured read data, and rejects malformed or out-of-range requests with an error flag. It sits entirely in the memory clock domain, downstream of the bridge's optional CDC stage.

## Interface
Parameters:
- `MEM_DATA_WIDTH`, default 64: data width of the request path and the SRAM.
- `MEM_ADDR_WIDTH`, default 1: entry address width.
- `MEM_DEPTH`, default 2: number of implemented entries. Must satisfy 1 ≤ `MEM_DEPTH` ≤ 2^`MEM_ADDR_WIDTH`.
- `SRAM_RD_LATENCY`, default 1: number of cycles from the `sram_ce` read cycle to valid `sram_rdata`. Legal range 1..4.

Ports:
- `mem_clk` input, 1: the block's single clock.
- `mem_rst` input, 1: asynchronous, active-high reset.
- `mem_req_vld` input, 1: request level, held by upstream until it sees `mem_ack_vld`.
- `mem_ack_vld` output, 1: one-cycle completion pulse.
- `mem_addr` input, `MEM_ADDR_WIDTH`: entry address.
- `mem_wr_en` input, 1: write request.
- `mem_rd_en` input, 1: read request.
- `mem_wr_data` input, `MEM_DATA_WIDTH`: write data.
- `mem_rd_data` output, `MEM_DATA_WIDTH`: read data. Valid while `mem_ack_vld` is high; held afterwards.
- `mem_err` output, 1: error status, valid with `mem_ack_vld`.
- `sram_ce` output, 1: SRAM chip enable, one cycle per access.
- `sram_we` output, 1: SRAM write enable, qualified by `sram_ce`.
- `sram_addr` output, `MEM_ADDR_WIDTH`: SRAM address.
- `sram_wdata` output, `MEM_DATA_WIDTH`: SRAM write data.
- `sram_rdata` input, `MEM_DATA_WIDTH`: SRAM read data.

## Operation
- The FSM has four states: IDLE, WR, RD_WAIT and ACK. All outputs are registered.
- In IDLE, if `mem_req_vld`=1, the request fields are sampled:
  - If exactly one of `mem_wr_en`/`mem_rd_en` is 1 and `mem_addr` < `MEM_DEPTH`:
    - a write goes to WR;
    - a read loads the latency counter with `SRAM_RD_LATENCY` and goes to RD_WAIT.
    - In both cases the next cycle drives `sram_ce`=1, `sram_we`=`mem_wr_en`, and the sampled `sram_addr`/`sram_wdata`.
  - Otherwise (both enables set, neither set, or address out of range):
    - go straight to ACK with `mem_err`=1;
    - no SRAM access occurs;
    - `mem_rd_data` is forced to 0.
- WR: one `sram_ce` cycle, then go to ACK with `mem_err`=0.
- RD_WAIT:
  - `sram_ce` is high only on the first cycle.
  - The counter decrements each cycle.
  - When the counter reaches 0, `sram_rdata` is captured into `mem_rd_data` and the FSM goes to ACK with `mem_err`=0.
- ACK:
  - `mem_ack_vld`=1 for exactly one cycle.
  - `mem_req_vld` is ignored during this cycle.
  - Then return to IDLE.
- Upstream must deassert `mem_req_vld` by the cycle after `mem_ack_vld`. A request still high in IDLE is a new transaction.
- Changes on the request fields outside IDLE are ignored, because the fields are latched at acceptance.
- `mem_rd_data` holds its last value except on error acks. A write ack leaves it unchanged.
- The latency counter width is clog2(`SRAM_RD_LATENCY`+1). It never wraps.

## Timing
- Reset values: all outputs 0; state IDLE; latency counter 0; latched fields 0.
- Reset asserted mid-transaction:
  - state returns to IDLE immediately and asynchronously;
  - `sram_ce` drops;
  - the in-flight read is discarded and no ack is issued;
  - `mem_rd_data` is cleared.
- Cycle numbering: request sampled in IDLE at cycle 0.
  - Write: `sram_ce`/`sram_we` high in cycle 1, `mem_ack_vld` high in cycle 2. Total latency is 2.
  - Read: `sram_ce` high in cycle 1. `sram_rdata` is valid in cycle 1+L and captured at the end of that cycle. `mem_ack_vld` and `mem_rd_data` are valid in cycle 2+L. For L=1 the latency is 3.
  - Error: `mem_ack_vld`=1 and `mem_err`=1 in cycle 1, and `sram_ce` stays 0 throughout.
- Back-to-back: with the ack in cycle N, the earliest next acceptance is cycle N+1. Maximum throughput is one write per 3 cycles, or one read per 3+L cycles.
- `sram_addr`/`sram_wdata` hold their values until the next access. `sram_we`=0 whenever `sram_ce`=0.

## Test plan
- Reset then idle: release `mem_rst`, hold `mem_req_vld`=0 for 20 cycles → all outputs 0 and no `sram_ce`.
- Write then read, L=1: write addr 1 data 64'hDEAD_BEEF_0123_4567 → `sram_ce`+`sram_we` in cycle 1, ack in cycle 2, `mem_err`=0. Read addr 1 → ack in cycle 3, `mem_rd_data`=64'hDEAD_BEEF_0123_4567.
- Latency sweep: `SRAM_RD_LATENCY`=1,2,4 with read requests → ack arrives exactly in cycle 3, 4 and 6 respectively, and `sram_ce` is high for exactly 1 cycle each time.
- Errors: `mem_wr_en`=`mem_rd_en`=1; then both 0; then addr 3 with `MEM_DEPTH`=3 and `MEM_ADDR_WIDTH`=2 → each acks in cycle 1 with `mem_err`=1, `mem_rd_data`=0 and no `sram_ce`.
- Held request: keep `mem_req_vld`=1 continuously with alternating write/read fields → accepted every 3 (write) or 3+L (read) cycles, and the request is ignored in ACK cycles.
- Reset mid-read (L=4): assert `mem_rst` in cycle 3 → no ack, outputs 0. The first post-reset read returns the SRAM content correctly.
